// File: rtl/dvbs2x_tx_symb_rate_switch_ctrl.sv
// dvbs2x_tx_symb_rate_switch_ctrl
// Sequences a run-time symbol-rate change for the TX symbol-rate divider:
// finish the current frame, hold off the stream, drain the divider, apply the
// new select with a flush pulse, settle, then release traffic.
// Sits inline on the AXIS handshake path ahead of the divider; data bypasses it.
// Optional statistics (switch_count, last_switch_cycles) are built only when
// DVBS2X_RATE_SWITCH_STATS_EN is defined; otherwise both outputs are tied to 0.
//
// Handshake: a beat moves when s_tvalid & s_tready (equivalently m_tvalid &
// m_tready); gate forces both m_tvalid and s_tready low. A request is taken when
// req_valid & req_ready, and req_ready is high only in IDLE (requests arriving
// while busy are dropped, not queued).

module dvbs2x_tx_symb_rate_switch_ctrl #(
    parameter int NUM_RATES        = 8,
    parameter int DEFAULT_SEL      = 0,
    parameter int DRAIN_MIN_CYCLES = 64,
    parameter int SETTLE_CYCLES    = 16,
    parameter int FRAME_TIMEOUT    = 65535,
    localparam int SEL_W           = $clog2(NUM_RATES)
) (
    input  logic             clk_ifc,
    input  logic             areset_ifc,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_valid,
    output logic             req_ready,
    output logic [SEL_W-1:0] active_sel,
    output logic             div_flush,
    input  logic             div_empty,
    output logic             busy,
    output logic             err_range,
    output logic             err_timeout,
    input  logic             err_clear,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [15:0]      switch_count,
    output logic [15:0]      last_switch_cycles
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_DRAIN  = 3'd2,
        S_APPLY  = 3'd3,
        S_SETTLE = 3'd4
    } state_t;

    state_t           state;
    logic             gate;
    logic             in_frame;
    logic [SEL_W-1:0] pending_sel;
    logic [31:0]      cnt;

    logic beat, tlast_beat, in_frame_nxt;
    logic req_fire, sel_oob, switch_go;
    logic wait_timeout, drain_done, settle_done;
    logic range_set, timeout_set;

    assign m_tvalid = s_tvalid & ~gate;
    assign s_tready = m_tready & ~gate;
    assign m_tlast  = s_tlast;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    assign beat         = s_tvalid & s_tready;
    assign tlast_beat   = beat & s_tlast;
    // Frame status as it will be after this cycle's beat (if any).
    assign in_frame_nxt = beat ? ~s_tlast : in_frame;

    assign req_fire  = req_valid & req_ready;
    // One extra bit so NUM_RATES itself is representable in the comparison.
    assign sel_oob   = ({1'b0, req_sel} >= (SEL_W+1)'(NUM_RATES));
    assign switch_go = req_fire & ~sel_oob & (req_sel != active_sel);

    assign wait_timeout = (cnt >= 32'(FRAME_TIMEOUT - 1));
    assign drain_done   = (cnt >= 32'(DRAIN_MIN_CYCLES - 1)) & div_empty;
    assign settle_done  = (cnt >= 32'(SETTLE_CYCLES - 1));

    assign range_set   = req_fire & sel_oob;
    assign timeout_set = (state == S_WAIT) & ~tlast_beat & wait_timeout;

    // Switch sequencer: state, gate, select, flush pulse, frame tracking, shared counter.
    always_ff @(posedge clk_ifc or posedge areset_ifc) begin
        if (areset_ifc) begin
            state       <= S_IDLE;
            gate        <= 1'b0;
            div_flush   <= 1'b0;
            in_frame    <= 1'b0;
            active_sel  <= SEL_W'(DEFAULT_SEL);
            pending_sel <= SEL_W'(DEFAULT_SEL);
            cnt         <= '0;
        end else begin
            div_flush <= 1'b0;
            in_frame  <= in_frame_nxt;
            case (state)
                S_IDLE: begin
                    if (switch_go) begin
                        pending_sel <= req_sel;
                        if (in_frame_nxt) begin
                            // cnt tracks cycles since accept while waiting for tlast
                            state <= S_WAIT;
                            cnt   <= 32'd1;
                        end else begin
                            state <= S_DRAIN;
                            gate  <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (tlast_beat || wait_timeout) begin
                        state <= S_DRAIN;
                        gate  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state     <= S_APPLY;
                        div_flush <= 1'b1;
                    end else if (cnt < 32'(DRAIN_MIN_CYCLES - 1)) begin
                        // Stop counting once the minimum is met; only div_empty matters then.
                        cnt <= cnt + 32'd1;
                    end
                end
                S_APPLY: begin
                    active_sel <= pending_sel;
                    in_frame   <= 1'b0;
                    state      <= S_SETTLE;
                    cnt        <= '0;
                end
                S_SETTLE: begin
                    if (settle_done) begin
                        state <= S_IDLE;
                        gate  <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gate  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clear stays set.
    always_ff @(posedge clk_ifc or posedge areset_ifc) begin
        if (areset_ifc) begin
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_range   <= (err_range & ~err_clear) | range_set;
            err_timeout <= (err_timeout & ~err_clear) | timeout_set;
        end
    end

`ifdef DVBS2X_RATE_SWITCH_STATS_EN
    logic [15:0] sw_cnt;
    logic [15:0] dur_run;
    logic [15:0] dur_last;

    // Switch statistics: wrapping APPLY count and saturating accept-to-release duration.
    always_ff @(posedge clk_ifc or posedge areset_ifc) begin
        if (areset_ifc) begin
            sw_cnt   <= '0;
            dur_run  <= '0;
            dur_last <= '0;
        end else begin
            if (state == S_APPLY) begin
                sw_cnt <= sw_cnt + 16'd1;
            end
            if (switch_go) begin
                dur_run <= 16'd1;
            end else if (state != S_IDLE && dur_run != 16'hFFFF) begin
                dur_run <= dur_run + 16'd1;
            end
            if (state == S_SETTLE && settle_done) begin
                dur_last <= (dur_run == 16'hFFFF) ? 16'hFFFF : dur_run + 16'd1;
            end
        end
    end

    assign switch_count       = sw_cnt;
    assign last_switch_cycles = dur_last;
`else
    assign switch_count       = 16'd0;
    assign last_switch_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_dvbs2x_tx_symb_rate_switch_ctrl.sv
// Bench for dvbs2x_tx_symb_rate_switch_ctrl: directed scenarios plus a random
// phase, all checked every cycle against a timestamp-based reference model.
// Statistics expectations follow DVBS2X_RATE_SWITCH_STATS_EN.

module tb_dvbs2x_tx_symb_rate_switch_ctrl;

    localparam int NR   = 6;
    localparam int DEF  = 0;
    localparam int DMIN = 64;
    localparam int SET  = 16;
    localparam int FT   = 100;
    localparam int SW   = $clog2(NR);

    // ---------------- clock / reset / DUT ----------------
    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic [SW-1:0] req_sel    = '0;
    logic          req_valid  = 1'b0;
    logic          div_empty  = 1'b1;
    logic          err_clear  = 1'b0;
    logic          s_tvalid   = 1'b0;
    logic          s_tlast    = 1'b0;
    logic          m_tready   = 1'b1;
    logic          req_ready, div_flush, busy, err_range, err_timeout;
    logic          s_tready, m_tvalid, m_tlast;
    logic [SW-1:0] active_sel;
    logic [15:0]   switch_count, last_switch_cycles;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dvbs2x_tx_symb_rate_switch_ctrl #(
        .NUM_RATES(NR), .DEFAULT_SEL(DEF), .DRAIN_MIN_CYCLES(DMIN),
        .SETTLE_CYCLES(SET), .FRAME_TIMEOUT(FT)
    ) dut (
        .clk_ifc(clk), .areset_ifc(rst),
        .req_sel(req_sel), .req_valid(req_valid), .req_ready(req_ready),
        .active_sel(active_sel), .div_flush(div_flush), .div_empty(div_empty),
        .busy(busy), .err_range(err_range), .err_timeout(err_timeout),
        .err_clear(err_clear),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .switch_count(switch_count), .last_switch_cycles(last_switch_cycles)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (timestamps) ----------------
    // A switch is described by when it was accepted, when gating starts,
    // when the flush happens and when traffic is released.
    bit          m_sw;
    int          m_acc, m_dstart, m_apply, m_rel;
    int          m_pend, m_act, m_cnt, m_last;
    bit          m_inf, m_erng, m_eto;
    logic [SW-1:0] exp_q[$];

    task automatic model_reset();
        m_sw = 0; m_acc = 0; m_dstart = -1; m_apply = -1; m_rel = -1;
        m_pend = DEF; m_act = DEF; m_cnt = 0; m_last = 0;
        m_inf = 0; m_erng = 0; m_eto = 0;
        exp_q.delete();
    endtask

    initial model_reset();

    // DUT-side event log used by directed latency checks
    int            ev_flush = -1, ev_sel = -1, ev_rel = -1, ev_gate = -1;
    bit            gate_seen = 0, prev_busy = 0, prev_flush = 0;
    logic [SW-1:0] prev_sel = '0;

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        bit gate_e, beat, nif, ne_r, ne_t;
        if (rst) begin
            model_reset();
            prev_flush = 0;
        end
        gate_e = m_sw && (m_dstart >= 0) && (cyc >= m_dstart);

        chk("req_ready", int'(req_ready), int'(!m_sw));
        chk("busy", int'(busy), int'(m_sw));
        chk("div_flush", int'(div_flush), int'(m_sw && cyc == m_apply));
        chk("active_sel", int'(active_sel), m_act);
        chk("err_range", int'(err_range), int'(m_erng));
        chk("err_timeout", int'(err_timeout), int'(m_eto));
        chk("m_tvalid", int'(m_tvalid), int'(s_tvalid && !gate_e));
        chk("s_tready", int'(s_tready), int'(m_tready && !gate_e));
        chk("m_tlast", int'(m_tlast), int'(s_tlast));
`ifdef DVBS2X_RATE_SWITCH_STATS_EN
        chk("switch_count", int'(switch_count), m_cnt & 16'hFFFF);
        chk("last_switch_cycles", int'(last_switch_cycles), m_last);
`else
        chk("switch_count", int'(switch_count), 0);
        chk("last_switch_cycles", int'(last_switch_cycles), 0);
`endif
        if (prev_flush && !rst) begin
            if (exp_q.size() == 0) chk("switch_sel_queue", 0, 1);
            else chk("switch_sel", int'(active_sel), int'(exp_q.pop_front()));
        end

        if (div_flush) ev_flush = cyc;
        if (active_sel != prev_sel) ev_sel = cyc;
        prev_sel = active_sel;
        if (prev_busy && !busy) ev_rel = cyc;
        prev_busy = busy;
        if (!busy) gate_seen = 0;
        else if (!gate_seen && m_tready && !s_tready) begin
            gate_seen = 1;
            ev_gate = cyc;
        end
        prev_flush = div_flush;

        if (!rst) begin
            beat = s_tvalid && m_tready && !gate_e;
            nif  = beat ? !s_tlast : m_inf;
            ne_r = 0;
            ne_t = 0;
            if (!m_sw) begin
                if (req_valid) begin
                    if (int'(req_sel) >= NR) ne_r = 1;
                    else if (int'(req_sel) != m_act) begin
                        m_sw = 1; m_pend = int'(req_sel); m_acc = cyc;
                        m_apply = -1; m_rel = -1;
                        m_dstart = nif ? -1 : cyc + 1;
                    end
                end
            end else if (m_dstart < 0) begin
                if (beat && s_tlast) m_dstart = cyc + 1;
                else if (cyc - m_acc + 1 >= FT) begin
                    m_dstart = cyc + 1;
                    ne_t = 1;
                end
            end else if (m_apply < 0) begin
                if (cyc - m_dstart >= DMIN - 1 && div_empty) begin
                    m_apply = cyc + 1;
                    m_rel   = cyc + 2 + SET;
                end
            end else if (cyc == m_apply) begin
                m_act = m_pend;
                m_cnt++;
                nif = 0;
                exp_q.push_back(SW'(m_pend));
            end else if (cyc == m_rel - 1) begin
                m_sw = 0;
                m_last = (m_rel - m_acc > 65535) ? 65535 : m_rel - m_acc;
            end
            m_inf  = nif;
            m_erng = (m_erng && !err_clear) || ne_r;
            m_eto  = (m_eto && !err_clear) || ne_t;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int acc_cyc = 0;
    task automatic request(input int sel);
        req_sel   = SW'(sel);
        req_valid = 1'b1;
        acc_cyc   = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    int beat_cyc = 0;
    task automatic send_beat(input bit last, output bit ok);
        s_tvalid = 1'b1;
        s_tlast  = last;
        @(negedge clk);
        ok = s_tready;
        beat_cyc = cyc;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc && busy; i++) tick();
        chk("wait_idle", int'(busy), 0);
        tick();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int n_ok, tl_cyc, t_rise, fl_before;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_active_sel", int'(active_sel), DEF);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        rst = 1'b0;
        tick();

        // 1: idle stream, immediate drain, 0 -> 3
        request(3);
        wait_idle(300);
        chk("t1_flush_latency", ev_flush - acc_cyc, 65);
        chk("t1_sel_latency", ev_sel - acc_cyc, 66);
        chk("t1_release_latency", ev_rel - acc_cyc, 82);
        chk("t1_sready_after", int'(s_tready), 1);
        chk("t1_active_sel", int'(active_sel), 3);
`ifdef DVBS2X_RATE_SWITCH_STATS_EN
        chk("t1_switch_count", int'(switch_count), 1);
        chk("t1_last_cycles", int'(last_switch_cycles), 82);
`endif

        // 2: request mid-frame (5 of 10 beats sent)
        n_ok = 0;
        for (int i = 0; i < 5; i++) begin send_beat(1'b0, ok); n_ok += int'(ok); end
        request(2);
        chk("t2_busy_in_frame", int'(busy), 1);
        for (int i = 0; i < 5; i++) begin
            send_beat(i == 4, ok);
            n_ok += int'(ok);
        end
        tl_cyc = beat_cyc;
        chk("t2_beats_passed", n_ok, 10);
        wait_idle(300);
        chk("t2_first_gated", ev_gate - tl_cyc, 1);
        chk("t2_active_sel", int'(active_sel), 2);

        // 3: no-op request, out-of-range request, err_clear
        request(2);
        chk("t3_same_no_busy", int'(busy), 0);
        request(7);
        chk("t3_range_set", int'(err_range), 1);
        chk("t3_range_no_busy", int'(busy), 0);
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("t3_range_cleared", int'(err_range), 0);
        err_clear = 1'b1;
        request(6);
        err_clear = 1'b0;
        chk("t3_error_beats_clear", int'(err_range), 1);
        err_clear = 1'b1; tick(); err_clear = 1'b0;

        // 4: frame never ends -> forced switch after FT cycles
        send_beat(1'b0, ok);
        request(5);
        wait_idle(400);
        chk("t4_drain_at", ev_gate - acc_cyc, 100);
        chk("t4_err_timeout", int'(err_timeout), 1);
        chk("t4_active_sel", int'(active_sel), 5);
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("t4_timeout_cleared", int'(err_timeout), 0);

        // 5: divider slow to empty, requests during switch ignored
        div_empty = 1'b0;
        fl_before = ev_flush;
        request(1);
        for (int i = 0; i < 200; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_sel   = SW'($urandom_range(0, 5));
            tick();
        end
        req_valid = 1'b0;
        chk("t5_still_busy", int'(busy), 1);
        chk("t5_no_flush_yet", ev_flush, fl_before);
        div_empty = 1'b1;
        t_rise = cyc;
        wait_idle(100);
        chk("t5_apply_latency", ev_flush - t_rise, 1);
        chk("t5_active_sel", int'(active_sel), 1);

        // 6: reset during SETTLE
        request(4);
        repeat (70) tick();
        chk("t6_in_settle_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_active_sel", int'(active_sel), DEF);
        chk("t6_rst_flush", int'(div_flush), 0);
        chk("t6_rst_sready", int'(s_tready), 1);
        tick(); tick();
        rst = 1'b0;
        m_tready = 1'b0;
        tick();
        chk("t6_sready_low", int'(s_tready), 0);
        m_tready = 1'b1;
        #1;
        chk("t6_sready_high", int'(s_tready), 1);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            s_tvalid  = ($urandom_range(0, 9) < 7);
            s_tlast   = ($urandom_range(0, 4) == 0);
            m_tready  = ($urandom_range(0, 9) < 8);
            div_empty = ($urandom_range(0, 3) != 0);
            req_valid = ($urandom_range(0, 39) == 0);
            req_sel   = SW'($urandom_range(0, 7));
            err_clear = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 1499) == 0);
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; err_clear = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1; div_empty = 1'b1;
        wait_idle(500);
        tick();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
